// File: rtl/shader_affine_inverse.sv
// Iterative 2x2 affine matrix inverse in signed Q4.8: one determinant cycle,
// then a shared restoring divider producing one quotient bit per clock.
module shader_affine_inverse (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic [11:0] qm [4],
  output logic        busy,
  output logic        done,
  output logic        singular,
  output logic        saturated,
  output logic [11:0] qi [4]
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DET  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Magnitude of a 13-bit signed adjugate entry; never exceeds 2048.
  function automatic logic [11:0] mag13(input logic [12:0] v);
    return 12'(v[12] ? (13'd0 - v) : v);
  endfunction

  // Clip a quotient magnitude to Q4.8 range and apply the sign; MSB flags a clip.
  function automatic logic [12:0] clip_q(input logic [27:0] q, input logic neg);
    logic [12:0] r;
    if (neg) begin
      if (q > 28'd2048) r = {1'b1, 12'h800};
      else              r = {1'b0, 12'd0 - q[11:0]};
    end else begin
      if (q > 28'd2047) r = {1'b1, 12'h7FF};
      else              r = {1'b0, q[11:0]};
    end
    return r;
  endfunction

  state_t      state_r, state_nx_s;
  logic [11:0] m_r [4];
  logic [24:0] det_r;
  logic [1:0]  idx_r;
  logic [4:0]  cnt_r;
  logic [27:0] dq_r;
  logic [25:0] rem_r;
  logic        adj_neg_r;
  logic [11:0] stg_r [4];
  logic        sat_r;

  logic signed [23:0] a24_s, b24_s, c24_s, d24_s, ad_s, bc_s;
  logic [24:0] det_s, dsr_s;
  logic [12:0] adj13_s;
  logic [11:0] adj_mag_s;
  logic [26:0] rem_sh_s;
  logic        ge_s, fin_s, sat_nx_s;
  logic [25:0] rem_nx_s;
  logic [27:0] q_nx_s;
  logic [12:0] res_s;
  logic [11:0] stg_nx_s [4];
  logic        busy_s, done_s, sing_o_s, sat_o_s;
  logic [11:0] qi_nx_s [4];

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:  if (start) state_nx_s = S_DET; else state_nx_s = S_IDLE;
      S_DET:   if (det_s == 25'd0) state_nx_s = S_DONE; else state_nx_s = S_DIV;
      S_DIV:   if (fin_s && (idx_r == 2'd3)) state_nx_s = S_DONE; else state_nx_s = S_DIV;
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Determinant: full 24-bit products, 25-bit difference so it never wraps.
  always_comb begin
    a24_s = {{12{m_r[0][11]}}, m_r[0]};
    b24_s = {{12{m_r[1][11]}}, m_r[1]};
    c24_s = {{12{m_r[2][11]}}, m_r[2]};
    d24_s = {{12{m_r[3][11]}}, m_r[3]};
    ad_s  = a24_s * d24_s;
    bc_s  = b24_s * c24_s;
    det_s = {ad_s[23], ad_s} - {bc_s[23], bc_s};
    dsr_s = det_r[24] ? (25'd0 - det_r) : det_r;
  end

  // Adjugate selection and one restoring-division step.
  always_comb begin
    case (idx_r)
      2'd0:    adj13_s = {m_r[3][11], m_r[3]};
      2'd1:    adj13_s = 13'd0 - {m_r[1][11], m_r[1]};
      2'd2:    adj13_s = 13'd0 - {m_r[2][11], m_r[2]};
      2'd3:    adj13_s = {m_r[0][11], m_r[0]};
      default: adj13_s = 13'd0;
    endcase
    adj_mag_s = mag13(adj13_s);
    rem_sh_s  = {rem_r, dq_r[27]};
    ge_s      = (rem_sh_s >= {2'b00, dsr_s});
    rem_nx_s  = 26'(ge_s ? (rem_sh_s - {2'b00, dsr_s}) : rem_sh_s);
    q_nx_s    = {dq_r[26:0], ge_s};
    res_s     = clip_q(q_nx_s, adj_neg_r ^ det_r[24]);
    fin_s     = (state_r == S_DIV) && (cnt_r == 5'd28);
    sat_nx_s  = sat_r | (fin_s & res_s[12]);
    stg_nx_s  = stg_r;
    if (fin_s) stg_nx_s[idx_r] = res_s[11:0];
    else       stg_nx_s[idx_r] = stg_r[idx_r];
  end

  // Datapath: operand latch, determinant, divider iteration and staging.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_r       <= '{default: 12'd0};
      det_r     <= 25'd0;
      idx_r     <= 2'd0;
      cnt_r     <= 5'd0;
      dq_r      <= 28'd0;
      rem_r     <= 26'd0;
      adj_neg_r <= 1'b0;
      stg_r     <= '{default: 12'd0};
      sat_r     <= 1'b0;
    end else begin
      stg_r <= stg_nx_s;
      sat_r <= sat_nx_s;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            m_r   <= qm;
            sat_r <= 1'b0;
          end
        end
        S_DET: begin
          det_r <= det_s;
          idx_r <= 2'd0;
          cnt_r <= 5'd0;
        end
        S_DIV: begin
          if (cnt_r == 5'd0) begin
            dq_r      <= {adj_mag_s, 16'd0};
            rem_r     <= 26'd0;
            adj_neg_r <= adj13_s[12];
            cnt_r     <= 5'd1;
          end else begin
            dq_r  <= q_nx_s;
            rem_r <= rem_nx_s;
            if (fin_s) begin
              cnt_r <= 5'd0;
              idx_r <= idx_r + 2'd1;
            end else begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
        end
        S_DONE:  begin end
        default: begin end
      endcase
    end
  end

  // Output decode from the next state so outputs line up with the state.
  always_comb begin
    busy_s = (state_nx_s != S_IDLE);
    done_s = (state_nx_s == S_DONE);
    if (state_r == S_DET) begin
      qi_nx_s  = '{default: 12'd0};
      sing_o_s = 1'b1;
      sat_o_s  = 1'b0;
    end else begin
      qi_nx_s  = stg_nx_s;
      sing_o_s = 1'b0;
      sat_o_s  = sat_nx_s;
    end
  end

  // Output registers; results only move on entry to DONE.
  always_ff @(posedge aclk) begin
    if (areset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      singular  <= 1'b0;
      saturated <= 1'b0;
      qi        <= '{default: 12'd0};
    end else begin
      busy <= busy_s;
      done <= done_s;
      if (done_s) begin
        qi        <= qi_nx_s;
        singular  <= sing_o_s;
        saturated <= sat_o_s;
      end
    end
  end

endmodule

// File: tb/tb_shader_affine_inverse.sv
// Directed bench for shader_affine_inverse with hand-computed expected inverses.
module tb_shader_affine_inverse;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] qm [4];
  logic        busy, done, singular, saturated;
  logic [11:0] qi [4];

  int tests = 0;
  int fails = 0;

  shader_affine_inverse dut (
    .aclk(aclk), .areset(areset), .start(start), .qm(qm),
    .busy(busy), .done(done), .singular(singular), .saturated(saturated), .qi(qi)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start one operation from IDLE and wait (bounded) for done; leaves us at the done negedge.
  task automatic do_op(input logic [11:0] a, b, c, d, output int lat, output int bcnt, output bit moved);
    logic [11:0] prev [4];
    @(negedge aclk);
    qm[0] = a; qm[1] = b; qm[2] = c; qm[3] = d;
    start = 1'b1;
    prev = qi;
    @(negedge aclk);
    start = 1'b0;
    lat = 0; bcnt = 0; moved = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (busy) bcnt++;
      if (done) begin lat = n; break; end
      if (qi != prev) moved = 1'b1;
      @(negedge aclk);
    end
  endtask

  task automatic chk_res(input string tag, input logic [11:0] e0, e1, e2, e3,
                         input logic es, input logic esat);
    chk({tag, ".qi0"}, 32'(qi[0]), 32'(e0));
    chk({tag, ".qi1"}, 32'(qi[1]), 32'(e1));
    chk({tag, ".qi2"}, 32'(qi[2]), 32'(e2));
    chk({tag, ".qi3"}, 32'(qi[3]), 32'(e3));
    chk({tag, ".singular"}, 32'(singular), 32'(es));
    chk({tag, ".saturated"}, 32'(saturated), 32'(esat));
  endtask

  initial begin
    int lat, bcnt, dcnt, d1, d2;
    bit moved, hold_bad;
    logic [11:0] q1 [4];
    logic [11:0] q2 [4];
    qm = '{default: 12'd0};

    // Reset state
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk_res("rst", 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0);

    // Identity: latency and busy width
    do_op(12'h100, 12'h000, 12'h000, 12'h100, lat, bcnt, moved);
    chk("ident.latency", 32'(lat), 32'd118);
    chk("ident.busy_cycles", 32'(bcnt), 32'd118);
    chk("ident.qi_held", 32'(moved), 32'd0);
    chk_res("ident", 12'h100, 12'h000, 12'h000, 12'h100, 1'b0, 1'b0);
    @(negedge aclk);
    chk("ident.busy_after", 32'(busy), 32'd0);
    chk("ident.done_pulse", 32'(done), 32'd0);
    chk("ident.qi_hold", 32'(qi[0]), 32'h100);

    do_op(12'h200, 12'h000, 12'h000, 12'h200, lat, bcnt, moved);
    chk("scale.latency", 32'(lat), 32'd118);
    chk_res("scale", 12'h080, 12'h000, 12'h000, 12'h080, 1'b0, 1'b0);

    do_op(12'h100, 12'h100, 12'h000, 12'h100, lat, bcnt, moved);
    chk_res("shear", 12'h100, 12'hF00, 12'h000, 12'h100, 1'b0, 1'b0);

    // det = 57344: 0x124, -146, -73, 0x124 after truncation toward zero
    do_op(12'h100, 12'h080, 12'h040, 12'h100, lat, bcnt, moved);
    chk_res("full", 12'h124, 12'hF6E, 12'hFB7, 12'h124, 1'b0, 1'b0);

    do_op(12'h100, 12'h100, 12'h100, 12'h100, lat, bcnt, moved);
    chk("sing.latency", 32'(lat), 32'd2);
    chk("sing.busy_cycles", 32'(bcnt), 32'd2);
    chk_res("sing", 12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 1'b0);

    do_op(12'h001, 12'h000, 12'h000, 12'h001, lat, bcnt, moved);
    chk_res("satpos", 12'h7FF, 12'h000, 12'h000, 12'h7FF, 1'b0, 1'b1);

    // diag(1/256, -1/256) inverts to diag(+256, -256), clipped to 0x7FF / 0x800
    do_op(12'h001, 12'h000, 12'h000, 12'hFFF, lat, bcnt, moved);
    chk_res("satneg", 12'h7FF, 12'h000, 12'h000, 12'h800, 1'b0, 1'b1);

    do_op(12'h300, 12'h000, 12'h000, 12'h100, lat, bcnt, moved);
    chk_res("trunc", 12'h055, 12'h000, 12'h000, 12'h100, 1'b0, 1'b0);

    do_op(12'hD00, 12'h000, 12'h000, 12'h100, lat, bcnt, moved);
    chk_res("trunc_neg", 12'hFAB, 12'h000, 12'h000, 12'h100, 1'b0, 1'b0);

    do_op(12'h800, 12'h000, 12'h000, 12'h800, lat, bcnt, moved);
    chk_res("minval", 12'hFE0, 12'h000, 12'h000, 12'hFE0, 1'b0, 1'b0);
    @(negedge aclk);

    // Back-to-back with start held high: identity then 2.0 scale
    @(negedge aclk);
    qm[0] = 12'h100; qm[1] = 12'h000; qm[2] = 12'h000; qm[3] = 12'h100;
    start = 1'b1;
    @(negedge aclk);
    qm[0] = 12'h200; qm[3] = 12'h200;
    dcnt = 0; d1 = 0; d2 = 0; hold_bad = 1'b0;
    q1 = '{default: 12'd0}; q2 = '{default: 12'd0};
    for (int n = 1; n <= 240; n++) begin
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = n; q1 = qi; end
        else if (dcnt == 2) begin d2 = n; q2 = qi; end
      end
      if (dcnt == 1 && !done && (qi[0] != 12'h100 || qi[3] != 12'h100)) hold_bad = 1'b1;
      if (n == 237) start = 1'b0;
      @(negedge aclk);
    end
    chk("b2b.done_count", 32'(dcnt), 32'd2);
    chk("b2b.first_done", 32'(d1), 32'd118);
    chk("b2b.second_done", 32'(d2), 32'd237);
    chk("b2b.first_qi0", 32'(q1[0]), 32'h100);
    chk("b2b.second_qi0", 32'(q2[0]), 32'h080);
    chk("b2b.second_qi3", 32'(q2[3]), 32'h080);
    chk("b2b.qi_held", 32'(hold_bad), 32'd0);
    chk("b2b.idle_busy", 32'(busy), 32'd0);

    // Mid-operation reset at T+50
    @(negedge aclk);
    qm[0] = 12'h300; qm[1] = 12'h000; qm[2] = 12'h000; qm[3] = 12'h100;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (49) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    chk_res("mrst", 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0);
    dcnt = 0;
    for (int n = 0; n < 130; n++) begin
      if (done) dcnt++;
      @(negedge aclk);
    end
    chk("mrst.no_done", 32'(dcnt), 32'd0);

    do_op(12'h100, 12'h000, 12'h000, 12'h100, lat, bcnt, moved);
    chk("post.latency", 32'(lat), 32'd118);
    chk_res("post", 12'h100, 12'h000, 12'h000, 12'h100, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
